// File: rtl/idex_hazard_ctrl.sv
// idex_hazard_ctrl: load-use stall and taken-branch flush control for the ID/EX stage, with saturating event counters
module idex_hazard_ctrl #(
    parameter int MEM_LAT     = 2,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  RDexe,
    input  logic        selWBexe,
    input  logic        selMEMRDexe,
    input  logic        selBRANCHexe,
    input  logic        branch_taken,
    input  logic [3:0]  RAdec,
    input  logic [3:0]  RBdec,
    input  logic        useAdec,
    input  logic        useBdec,
    input  logic        validdec,
    output logic        stallPC,
    output logic        stallIFID,
    output logic        bubbleIDEX,
    output logic        flushIFID,
    output logic        busy,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
);
    typedef enum logic [1:0] {RUN, LDSTALL, FLUSH} state_t;
    localparam logic [3:0] ML_RELOAD = 4'(MEM_LAT - 1);
    localparam logic [3:0] FD_RELOAD = 4'(FLUSH_DEPTH - 1);
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_cycles_q, flush_events_q;
    logic        lu, tb, stall, bubble, flush;
    assign lu = validdec & selMEMRDexe & selWBexe &
                ((useAdec & (RAdec == RDexe)) | (useBdec & (RBdec == RDexe)));
    assign tb = selBRANCHexe & branch_taken;
    // A taken branch wins in every state, including aborting a load stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        flush   = 1'b0;
        if (tb) begin
            flush   = 1'b1;
            bubble  = 1'b1;
            state_d = (FLUSH_DEPTH > 1) ? FLUSH : RUN;
            cnt_d   = FD_RELOAD;
        end else if (state_q == FLUSH) begin
            flush   = 1'b1;
            bubble  = 1'b1;
            state_d = (cnt_q == 4'd1) ? RUN : FLUSH;
            cnt_d   = cnt_q - 4'd1;
        end else if (state_q == LDSTALL) begin
            stall   = 1'b1;
            bubble  = 1'b1;
            state_d = (cnt_q == 4'd1) ? RUN : LDSTALL;
            cnt_d   = cnt_q - 4'd1;
        end else if (lu) begin
            stall   = 1'b1;
            bubble  = 1'b1;
            state_d = (MEM_LAT > 1) ? LDSTALL : RUN;
            cnt_d   = ML_RELOAD;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            cnt_q          <= 4'd0;
            stall_cycles_q <= 16'd0;
            flush_events_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_q + {15'd0, stall & ~&stall_cycles_q};
            flush_events_q <= flush_events_q + {15'd0, tb & ~&flush_events_q};
        end
    end
    // Controls are masked while in reset since RUN alone would still react to inputs.
    assign stallPC      = rst_n & stall;
    assign stallIFID    = rst_n & stall;
    assign bubbleIDEX   = rst_n & bubble;
    assign flushIFID    = rst_n & flush;
    assign busy         = rst_n & (state_q != RUN);
    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// tb_idex_hazard_ctrl: directed vector table plus reset, abort and saturation sequences for idex_hazard_ctrl
module tb_idex_hazard_ctrl;
    localparam int K_IDLE = 0, K_LU = 1, K_NOA = 2, K_TB = 3, K_BNT = 4, K_LUTB = 5, K_LUB = 6, K_NOWB = 7;
    logic clk, rst_n;
    logic [3:0] RDexe, RAdec, RBdec;
    logic selWBexe, selMEMRDexe, selBRANCHexe, branch_taken, useAdec, useBdec, validdec;
    logic spc0, sif0, bub0, fl0, busy0, spc1, sif1, bub1, fl1, busy1;
    logic [15:0] sc0, fe0, sc1, fe1;
    logic [4:0] o0, o1;
    int pass_cnt = 0, total_cnt = 0;
    typedef struct {
        int k;
        logic [4:0] e0, e1;
        int sc0, sc1, fe;
    } vec_t;
    vec_t vt[27];

    assign o0 = {spc0, sif0, bub0, fl0, busy0};
    assign o1 = {spc1, sif1, bub1, fl1, busy1};

    idex_hazard_ctrl #(.MEM_LAT(2), .FLUSH_DEPTH(2)) u0 (
        .clk(clk), .rst_n(rst_n), .RDexe(RDexe), .selWBexe(selWBexe), .selMEMRDexe(selMEMRDexe),
        .selBRANCHexe(selBRANCHexe), .branch_taken(branch_taken), .RAdec(RAdec), .RBdec(RBdec),
        .useAdec(useAdec), .useBdec(useBdec), .validdec(validdec), .stallPC(spc0), .stallIFID(sif0),
        .bubbleIDEX(bub0), .flushIFID(fl0), .busy(busy0), .stall_cycles(sc0), .flush_events(fe0));
    idex_hazard_ctrl #(.MEM_LAT(4), .FLUSH_DEPTH(2)) u1 (
        .clk(clk), .rst_n(rst_n), .RDexe(RDexe), .selWBexe(selWBexe), .selMEMRDexe(selMEMRDexe),
        .selBRANCHexe(selBRANCHexe), .branch_taken(branch_taken), .RAdec(RAdec), .RBdec(RBdec),
        .useAdec(useAdec), .useBdec(useBdec), .validdec(validdec), .stallPC(spc1), .stallIFID(sif1),
        .bubbleIDEX(bub1), .flushIFID(fl1), .busy(busy1), .stall_cycles(sc1), .flush_events(fe1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic set_in(input int k);
        RDexe = 4'h5; RAdec = 4'h3; RBdec = 4'h3;
        useAdec = 0; useBdec = 0; validdec = 0;
        selWBexe = 0; selMEMRDexe = 0; selBRANCHexe = 0; branch_taken = 0;
        if (k == K_LU || k == K_NOA || k == K_LUTB || k == K_NOWB) begin
            RAdec = 4'h5; useAdec = (k != K_NOA); validdec = 1;
            selMEMRDexe = 1; selWBexe = (k != K_NOWB);
        end
        if (k == K_LUB) begin
            RBdec = 4'h5; useBdec = 1; validdec = 1; selMEMRDexe = 1; selWBexe = 1;
        end
        if (k == K_TB || k == K_LUTB || k == K_BNT) begin
            selBRANCHexe = 1; branch_taken = (k != K_BNT);
        end
    endtask

    initial begin
        // {stallPC, stallIFID, bubbleIDEX, flushIFID, busy} for MEM_LAT=2 and MEM_LAT=4
        vt[0]  = '{K_LU,   5'b11100, 5'b11100, 0, 0, 0};
        vt[1]  = '{K_IDLE, 5'b11101, 5'b11101, 1, 1, 0};
        vt[2]  = '{K_IDLE, 5'b00000, 5'b11101, 2, 2, 0};
        vt[3]  = '{K_IDLE, 5'b00000, 5'b11101, 2, 3, 0};
        vt[4]  = '{K_IDLE, 5'b00000, 5'b00000, 2, 4, 0};
        vt[5]  = '{K_NOA,  5'b00000, 5'b00000, 2, 4, 0};
        vt[6]  = '{K_BNT,  5'b00000, 5'b00000, 2, 4, 0};
        vt[7]  = '{K_NOWB, 5'b00000, 5'b00000, 2, 4, 0};
        vt[8]  = '{K_TB,   5'b00110, 5'b00110, 2, 4, 0};
        vt[9]  = '{K_IDLE, 5'b00111, 5'b00111, 2, 4, 1};
        vt[10] = '{K_IDLE, 5'b00000, 5'b00000, 2, 4, 1};
        vt[11] = '{K_LUTB, 5'b00110, 5'b00110, 2, 4, 1};
        vt[12] = '{K_IDLE, 5'b00111, 5'b00111, 2, 4, 2};
        vt[13] = '{K_LU,   5'b11100, 5'b11100, 2, 4, 2};
        vt[14] = '{K_IDLE, 5'b11101, 5'b11101, 3, 5, 2};
        vt[15] = '{K_TB,   5'b00110, 5'b00111, 4, 6, 2};
        vt[16] = '{K_IDLE, 5'b00111, 5'b00111, 4, 6, 3};
        vt[17] = '{K_IDLE, 5'b00000, 5'b00000, 4, 6, 3};
        vt[18] = '{K_TB,   5'b00110, 5'b00110, 4, 6, 3};
        vt[19] = '{K_TB,   5'b00111, 5'b00111, 4, 6, 4};
        vt[20] = '{K_LU,   5'b00111, 5'b00111, 4, 6, 5};
        vt[21] = '{K_IDLE, 5'b00000, 5'b00000, 4, 6, 5};
        vt[22] = '{K_LUB,  5'b11100, 5'b11100, 4, 6, 5};
        vt[23] = '{K_LU,   5'b11101, 5'b11101, 5, 7, 5};
        vt[24] = '{K_LU,   5'b11100, 5'b11101, 6, 8, 5};
        vt[25] = '{K_IDLE, 5'b11101, 5'b11101, 7, 9, 5};
        vt[26] = '{K_IDLE, 5'b00000, 5'b00000, 8, 10, 5};

        rst_n = 0;
        set_in(K_LU);
        #2;
        chk("rst lu ctl0", {11'd0, o0}, 16'd0);
        chk("rst lu ctl1", {11'd0, o1}, 16'd0);
        chk("rst sc0", sc0, 16'd0);
        chk("rst fe0", fe0, 16'd0);
        set_in(K_TB);
        #1;
        chk("rst tb ctl0", {11'd0, o0}, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst hold fe0", fe0, 16'd0);
        chk("rst hold sc1", sc1, 16'd0);
        set_in(K_IDLE);
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d ctl0", i), {11'd0, o0}, 16'd0);
            chk($sformatf("idle%0d ctl1", i), {11'd0, o1}, 16'd0);
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 27; i++) begin
            set_in(vt[i].k);
            @(negedge clk);
            chk($sformatf("v%0d ctl0", i), {11'd0, o0}, {11'd0, vt[i].e0});
            chk($sformatf("v%0d ctl1", i), {11'd0, o1}, {11'd0, vt[i].e1});
            chk($sformatf("v%0d sc0", i), sc0, 16'(vt[i].sc0));
            chk($sformatf("v%0d sc1", i), sc1, 16'(vt[i].sc1));
            chk($sformatf("v%0d fe0", i), fe0, 16'(vt[i].fe));
            chk($sformatf("v%0d fe1", i), fe1, 16'(vt[i].fe));
            @(posedge clk);
            #1;
        end

        // asynchronous reset in the middle of a flush
        set_in(K_TB);
        @(posedge clk);
        #1;
        set_in(K_IDLE);
        #1;
        chk("mid flush ctl0", {11'd0, o0}, 16'b00111);
        rst_n = 0;
        #1;
        chk("async rst ctl0", {11'd0, o0}, 16'd0);
        chk("async rst ctl1", {11'd0, o1}, 16'd0);
        chk("async rst sc1", sc1, 16'd0);
        chk("async rst fe0", fe0, 16'd0);
        set_in(K_LU);
        #1;
        chk("async rst lu ctl1", {11'd0, o1}, 16'd0);
        @(posedge clk);
        #1;
        set_in(K_IDLE);
        rst_n = 1;
        @(negedge clk);
        chk("post rst ctl0", {11'd0, o0}, 16'd0);
        chk("post rst ctl1", {11'd0, o1}, 16'd0);
        set_in(K_LU);
        #1;
        chk("post rst lu ctl0", {11'd0, o0}, 16'b11100);
        chk("post rst lu ctl1", {11'd0, o1}, 16'b11100);

        // continuous load-use keeps stallPC high every cycle until the counter saturates
        @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        rst_n = 1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat pre sc0", sc0, 16'hFFFE);
        chk("sat pre sc1", sc1, 16'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        chk("sat sc0", sc0, 16'hFFFF);
        chk("sat sc1", sc1, 16'hFFFF);
        chk("sat fe0", fe0, 16'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
